// File: rtl/out_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : out_port_ctrl
// Description : CPU output-port controller. CPU writes are buffered in a small
//               FIFO and handed to an external device one word at a time over
//               a 4-phase valid/ack handshake (IDLE -> PRESENT -> RELEASE).
// Revision    : 1.0 - initial release
//
// Ports
//   clock           in   1           single clock, rising edge
//   clear           in   1           asynchronous active-high reset
//   out_wr          in   1           CPU write strobe
//   BusMuxOut       in   DATA_WIDTH  CPU bus word to buffer
//   out_busy        out  1           FIFO full, CPU must stall its write
//   External_Output out  DATA_WIDTH  registered word shown to the device
//   out_valid       out  1           External_Output awaits acknowledge
//   ext_ack         in   1           device acknowledge (synchronous)
//   fifo_count      out  log2(D)+1   number of buffered words
//   timeout_err     out  1           sticky handshake-timeout flag
//
// Build option
//   OUT_PORT_TIMEOUT_EN : when defined, a word left unacknowledged for TIMEOUT
//                         PRESENT cycles is dropped and timeout_err is set.
//                         When undefined PRESENT waits forever and
//                         timeout_err is tied low.
// ============================================================================
module out_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          out_wr,
    input  logic [DATA_WIDTH-1:0]         BusMuxOut,
    output logic                          out_busy,
    output logic [DATA_WIDTH-1:0]         External_Output,
    output logic                          out_valid,
    input  logic                          ext_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_ext_data;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_timeout;

    assign w_full = (r_count == c_FULL);
    // Fullness is judged before any pop of the same edge, so a write while
    // full is lost even if a slot frees up on that edge.
    assign w_push = out_wr && !w_full;
    // The device must have returned ack low (end of the previous 4-phase
    // cycle) before a new word is popped.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && !ext_ack;

`ifdef OUT_PORT_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_timeout_err;

    // Counter is zero on the first PRESENT cycle, so reaching TIMEOUT-1
    // without ack means TIMEOUT full cycles have been spent presenting.
    assign w_timeout = (r_state == S_PRESENT) && !ext_ack && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_PRESENT) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                out_valid = 1'b1;
                if (ext_ack) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!ext_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage: data array carries no reset, only pointers/count do
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= BusMuxOut;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ext_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                r_ext_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_busy        = w_full;
    assign External_Output = r_ext_data;
    assign fifo_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_out_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_ctrl
// Description : Self-checking bench for out_port_ctrl. A queue-based reference
//               model of the output port predicts every output after each
//               clock edge; directed scenarios are mixed with random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic                     clock = 1'b0;
    logic                     clear;
    logic                     out_wr;
    logic [DW-1:0]            BusMuxOut;
    logic                     out_busy;
    logic [DW-1:0]            External_Output;
    logic                     out_valid;
    logic                     ext_ack;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     timeout_err;

    out_port_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clock           (clock),
        .clear           (clear),
        .out_wr          (out_wr),
        .BusMuxOut       (BusMuxOut),
        .out_busy        (out_busy),
        .External_Output (External_Output),
        .out_valid       (out_valid),
        .ext_ack         (ext_ack),
        .fifo_count      (fifo_count),
        .timeout_err     (timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered words, the word on the port, and which part
    // of the handshake the port is in (0 waiting, 1 presenting, 2 releasing).
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_ext;
    int            m_phase;
    int            m_wait;
    bit            m_err;

    // Words the device actually accepted (sampled from the DUT pins).
    logic [DW-1:0] rx[$];
    logic [DW-1:0] exp_w[10];
    logic [DW-1:0] word_a;
    logic [DW-1:0] word_b;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext   = '0;
        m_phase = 0;
        m_wait  = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input bit wr, input logic [DW-1:0] d, input bit ack);
        bit full;
        full = (m_q.size() == DEPTH);
        case (m_phase)
            0: begin
                if (m_q.size() != 0 && !ack) begin
                    m_ext   = m_q.pop_front();
                    m_phase = 1;
                    m_wait  = 0;
                end
            end
            1: begin
                if (ack) begin
                    m_phase = 2;
                end
`ifdef OUT_PORT_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_phase = 0;
                        m_err   = 1'b1;
                    end
                end
`endif
            end
            default: begin
                if (!ack) m_phase = 0;
            end
        endcase
        if (wr && !full) m_q.push_back(d);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":count"}, DW'(fifo_count), DW'(m_q.size()));
        check({tag, ":busy"},  DW'(out_busy),   DW'(m_q.size() == DEPTH));
        check({tag, ":valid"}, DW'(out_valid),  DW'(m_phase == 1));
        check({tag, ":data"},  External_Output, m_ext);
        check({tag, ":terr"},  DW'(timeout_err), DW'(m_err));
    endtask

    // Apply inputs, advance one edge, then compare against the model.
    task automatic tick(input bit wr, input logic [DW-1:0] d, input bit ack, input string tag);
        out_wr    = wr;
        BusMuxOut = d;
        ext_ack   = ack;
        if (out_valid && ack) rx.push_back(External_Output);
        model_edge(wr, d, ack);
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    task automatic pulse_clear(input string tag);
        clear = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear     = 1'b1;
        out_wr    = 1'b0;
        ext_ack   = 1'b0;
        BusMuxOut = '0;
        model_reset();
        @(posedge clock);
        #1;
        compare_all("reset");
        clear = 1'b0;

        // Single word, device acks two cycles after valid rises.
        tick(1'b1, 32'hDEADBEEF, 1'b0, "db_push");
        check("db_count1", DW'(fifo_count), DW'(1));
        check("db_valid_early", DW'(out_valid), DW'(0));
        tick(1'b0, '0, 1'b0, "db_pop");
        check("db_valid", DW'(out_valid), DW'(1));
        check("db_data", External_Output, 32'hDEADBEEF);
        tick(1'b0, '0, 1'b0, "db_wait");
        tick(1'b0, '0, 1'b1, "db_ack");
        check("db_valid_drop", DW'(out_valid), DW'(0));
        tick(1'b0, '0, 1'b0, "db_rel");
        check("db_hold", External_Output, 32'hDEADBEEF);

        // Ack held high in IDLE: nothing pops, FIFO fills, 5th write lost.
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, DW'(i), 1'b1, "fill");
            if (i == 2) begin
                check("ackhi_count2", DW'(fifo_count), DW'(2));
                check("ackhi_nopop", DW'(out_valid), DW'(0));
            end
            if (i == 4) check("full_count4", DW'(fifo_count), DW'(4));
        end
        check("full_busy", DW'(out_busy), DW'(1));
        check("full_count", DW'(fifo_count), DW'(4));
        rx.delete();
        for (int c = 0; c < 40 && rx.size() < 4; c++) tick(1'b0, '0, out_valid, "drain");
        tick(1'b0, '0, 1'b0, "drain_end");
        check("drain_n", DW'(rx.size()), DW'(4));
        for (int i = 0; i < 4 && i < rx.size(); i++) check("drain_order", rx[i], DW'(i + 1));

        // Streaming: device acks in one cycle, CPU writes whenever not busy.
        for (int i = 0; i < 10; i++) exp_w[i] = $urandom;
        rx.delete();
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 100 && rx.size() < 10; c++) begin
                bit w;
                w = (sent < 10) && !out_busy;
                tick(w, exp_w[(sent < 10) ? sent : 0], out_valid, "stream");
                if (w) sent++;
            end
        end
        tick(1'b0, '0, 1'b0, "stream_end");
        check("stream_n", DW'(rx.size()), DW'(10));
        for (int i = 0; i < 10 && i < rx.size(); i++) check("stream_order", rx[i], exp_w[i]);

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            tick(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)), "rand");
        end

        // Long unacknowledged presentation.
        pulse_clear("clr1");
        word_a = $urandom;
        word_b = $urandom;
        tick(1'b1, word_a, 1'b0, "to_a");
        tick(1'b1, word_b, 1'b0, "to_b");
        for (int c = 0; c < 12; c++) tick(1'b0, '0, 1'b0, "to_wait");
`ifdef OUT_PORT_TIMEOUT_EN
        check("to_err", DW'(timeout_err), DW'(1));
        check("to_next", External_Output, word_b);
        for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b1, "to_sticky");
        check("to_err_sticky", DW'(timeout_err), DW'(1));
`else
        check("nto_valid", DW'(out_valid), DW'(1));
        check("nto_data", External_Output, word_a);
        check("nto_err", DW'(timeout_err), DW'(0));
`endif

        // Asynchronous clear while presenting with 3 words buffered.
        pulse_clear("clr2");
        for (int i = 0; i < 4; i++) tick(1'b1, DW'($urandom), 1'b0, "pre_clr");
        check("pre_clr_count", DW'(fifo_count), DW'(3));
        check("pre_clr_valid", DW'(out_valid), DW'(1));
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        check("aclr_valid", DW'(out_valid), DW'(0));
        check("aclr_count", DW'(fifo_count), DW'(0));
        check("aclr_data", External_Output, DW'(0));
        clear = 1'b0;

        // First edge after clear accepts a write.
        tick(1'b1, 32'h0000A5A5, 1'b1, "post_clr");
        check("post_clr_count", DW'(fifo_count), DW'(1));
        tick(1'b0, '0, 1'b0, "post_clr_pop");
        check("post_clr_data", External_Output, 32'h0000A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
